// File: rtl/dmem_stage_responder.sv
// M-stage data memory responder: word-organised RAM with byte/half/word access,
// fixed wait states, pipeline stall, load extension and misalignment detection.
module dmem_stage_responder #(
    parameter int unsigned DEPTH   = 1024,
    parameter int unsigned LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        write_enable_dmem_M,
    input  logic        read_req_M,
    input  logic [31:0] alu_rsl_M,
    input  logic [31:0] wd_M,
    input  logic [1:0]  store_sel_M,
    input  logic [2:0]  load_sel_M,
    output logic [31:0] rdata_M,
    output logic        stall_M,
    output logic        misalign_M
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;
    typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [AW+1:0]   addr_q;
    logic [31:0]     wd_q;
    logic            we_q;
    size_e           size_q;
    logic            uns_q;
    logic [31:0]     rdata_q;

    logic [31:0]     mem [DEPTH];

    logic            req_c;
    size_e           req_size_c;
    logic            req_uns_c;
    logic            mis_c;
    logic            latch_c;
    logic            access_c;
    logic [AW-1:0]   idx_c;
    logic [3:0]      be_c;
    logic [31:0]     wlane_c;
    logic [31:0]     rword_c;
    logic [7:0]      rbyte_c;
    logic [15:0]     rhalf_c;
    logic [31:0]     load_c;
    logic            unused_addr_bits;

    // Address bits above the RAM span are deliberately ignored (wrap-around).
    assign unused_addr_bits = ^alu_rsl_M[31:AW+2];

    // Request decode: a store wins when both request lines are high.
    always_comb begin
        req_c      = read_req_M | write_enable_dmem_M;
        req_size_c = SZ_W;
        req_uns_c  = 1'b0;
        if (write_enable_dmem_M) begin
            case (store_sel_M)
                2'b00:   req_size_c = SZ_B;
                2'b01:   req_size_c = SZ_H;
                default: req_size_c = SZ_W;
            endcase
        end else begin
            case (load_sel_M)
                3'b000:  req_size_c = SZ_B;
                3'b001:  req_size_c = SZ_H;
                3'b100: begin req_size_c = SZ_B; req_uns_c = 1'b1; end
                3'b101: begin req_size_c = SZ_H; req_uns_c = 1'b1; end
                default: req_size_c = SZ_W;
            endcase
        end
        mis_c = ((req_size_c == SZ_H) && alu_rsl_M[0])
             || ((req_size_c == SZ_W) && (alu_rsl_M[1:0] != 2'b00));
    end

    // State and latched-request registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wd_q    <= '0;
            we_q    <= 1'b0;
            size_q  <= SZ_W;
            uns_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (latch_c) begin
                addr_q <= alu_rsl_M[AW+1:0];
                wd_q   <= wd_M;
                we_q   <= write_enable_dmem_M;
                size_q <= req_size_c;
                uns_q  <= req_uns_c;
            end
            if (access_c && !we_q) begin
                rdata_q <= load_c;
            end
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        latch_c = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_c && !mis_c) begin
                    latch_c = 1'b1;
                    cnt_d   = CW'(LATENCY - 1);
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (cnt_q == '0) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output logic.
    always_comb begin
        stall_M    = 1'b0;
        misalign_M = 1'b0;
        access_c   = 1'b0;
        case (state_q)
            IDLE: begin
                stall_M    = req_c && !mis_c;
                misalign_M = req_c && mis_c;
            end
            BUSY: begin
                stall_M  = 1'b1;
                access_c = (cnt_q == '0);
            end
            default: ;
        endcase
    end

    assign rdata_M = rdata_q;

    // Lane enables and replicated store data.
    always_comb begin
        idx_c   = addr_q[AW+1:2];
        be_c    = 4'b1111;
        wlane_c = wd_q;
        case (size_q)
            SZ_B: begin
                be_c    = 4'b0001 << addr_q[1:0];
                wlane_c = {4{wd_q[7:0]}};
            end
            SZ_H: begin
                be_c    = addr_q[1] ? 4'b1100 : 4'b0011;
                wlane_c = {2{wd_q[15:0]}};
            end
            default: ;
        endcase
    end

    // Load lane select and extension.
    always_comb begin
        rword_c = mem[idx_c];
        rbyte_c = 8'(rword_c >> {addr_q[1:0], 3'b000});
        rhalf_c = addr_q[1] ? rword_c[31:16] : rword_c[15:0];
        case (size_q)
            SZ_B:    load_c = uns_q ? {24'd0, rbyte_c} : {{24{rbyte_c[7]}}, rbyte_c};
            SZ_H:    load_c = uns_q ? {16'd0, rhalf_c} : {{16{rhalf_c[15]}}, rhalf_c};
            default: load_c = rword_c;
        endcase
    end

    // RAM write port; a reset in the final BUSY cycle discards the store.
    always_ff @(posedge clk) begin
        if (rst_n && access_c && we_q) begin
            for (int i = 0; i < 4; i++) begin
                if (be_c[i]) begin
                    mem[idx_c][8*i +: 8] <= wlane_c[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_dmem_stage_responder.sv
// Directed bench for dmem_stage_responder (DEPTH=1024, LATENCY=2).
module tb_dmem_stage_responder;

    logic        clk;
    logic        rst_n;
    logic        write_enable_dmem_M;
    logic        read_req_M;
    logic [31:0] alu_rsl_M;
    logic [31:0] wd_M;
    logic [1:0]  store_sel_M;
    logic [2:0]  load_sel_M;
    logic [31:0] rdata_M;
    logic        stall_M;
    logic        misalign_M;

    int errors = 0;
    int checks = 0;

    localparam logic [1:0] SB = 2'b00, SH = 2'b01, SW = 2'b10;
    localparam logic [2:0] LB = 3'b000, LH = 3'b001, LW = 3'b010, LBU = 3'b100, LHU = 3'b101;

    dmem_stage_responder #(.DEPTH(1024), .LATENCY(2)) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .write_enable_dmem_M (write_enable_dmem_M),
        .read_req_M          (read_req_M),
        .alu_rsl_M           (alu_rsl_M),
        .wd_M                (wd_M),
        .store_sel_M         (store_sel_M),
        .load_sel_M          (load_sel_M),
        .rdata_M             (rdata_M),
        .stall_M             (stall_M),
        .misalign_M          (misalign_M)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle_inputs();
        write_enable_dmem_M = 1'b0;
        read_req_M          = 1'b0;
        alu_rsl_M           = '0;
        wd_M                = '0;
        store_sel_M         = '0;
        load_sel_M          = '0;
    endtask

    // Issues one request in an IDLE cycle and returns once stall_M drops
    // (DONE cycle, or the same cycle for a rejected request).
    task automatic access(input logic we, input logic re, input logic [31:0] a,
                          input logic [31:0] d, input logic [1:0] ss, input logic [2:0] ls,
                          output int stall_cycles, output logic mis_seen);
        @(posedge clk); #1;
        write_enable_dmem_M = we;
        read_req_M          = re;
        alu_rsl_M           = a;
        wd_M                = d;
        store_sel_M         = ss;
        load_sel_M          = ls;
        stall_cycles        = 0;
        #1;
        mis_seen = misalign_M;
        while (stall_M && stall_cycles < 20) begin
            stall_cycles++;
            @(posedge clk); #2;
        end
        if (stall_cycles >= 20) stall_cycles = 99;
        idle_inputs();
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        checks++; if (rdata_M !== 32'h0) begin errors++; $display("FAIL reset_rdata got=%h exp=%h", rdata_M, 32'h0); end
        checks++; if (stall_M !== 1'b0) begin errors++; $display("FAIL reset_stall got=%b exp=0", stall_M); end
        checks++; if (misalign_M !== 1'b0) begin errors++; $display("FAIL reset_misalign got=%b exp=0", misalign_M); end
    endtask

    task automatic test_word();
        int sc; logic m;
        access(1'b1, 1'b0, 32'h10, 32'hDEADBEEF, SW, LW, sc, m);
        checks++; if (sc !== 3) begin errors++; $display("FAIL sw_stall_cycles got=%0d exp=3", sc); end
        checks++; if (stall_M !== 1'b0) begin errors++; $display("FAIL sw_done_stall got=%b exp=0", stall_M); end
        access(1'b0, 1'b1, 32'h10, 32'h0, SW, LW, sc, m);
        checks++; if (sc !== 3) begin errors++; $display("FAIL lw_stall_cycles got=%0d exp=3", sc); end
        checks++; if (rdata_M !== 32'hDEADBEEF) begin errors++; $display("FAIL lw_word got=%h exp=%h", rdata_M, 32'hDEADBEEF); end
    endtask

    task automatic test_byte();
        int sc; logic m;
        access(1'b1, 1'b0, 32'h10, 32'h0, SW, LW, sc, m);
        access(1'b1, 1'b0, 32'h13, 32'hFFFFFF80, SB, LW, sc, m);
        access(1'b0, 1'b1, 32'h10, 32'h0, SW, LW, sc, m);
        checks++; if (rdata_M !== 32'h80000000) begin errors++; $display("FAIL sb_lane got=%h exp=%h", rdata_M, 32'h80000000); end
        access(1'b0, 1'b1, 32'h13, 32'h0, SW, LB, sc, m);
        checks++; if (rdata_M !== 32'hFFFFFF80) begin errors++; $display("FAIL lb_sext got=%h exp=%h", rdata_M, 32'hFFFFFF80); end
        access(1'b0, 1'b1, 32'h13, 32'h0, SW, LBU, sc, m);
        checks++; if (rdata_M !== 32'h00000080) begin errors++; $display("FAIL lbu_zext got=%h exp=%h", rdata_M, 32'h00000080); end
        access(1'b0, 1'b1, 32'h11, 32'h0, SW, LBU, sc, m);
        checks++; if (rdata_M !== 32'h00000000) begin errors++; $display("FAIL lbu_lane1 got=%h exp=%h", rdata_M, 32'h0); end
    endtask

    task automatic test_half();
        int sc; logic m;
        access(1'b1, 1'b0, 32'h20, 32'h0, SW, LW, sc, m);
        access(1'b1, 1'b0, 32'h22, 32'hABCD8001, SH, LW, sc, m);
        access(1'b0, 1'b1, 32'h22, 32'h0, SW, LH, sc, m);
        checks++; if (rdata_M !== 32'hFFFF8001) begin errors++; $display("FAIL lh_sext got=%h exp=%h", rdata_M, 32'hFFFF8001); end
        access(1'b0, 1'b1, 32'h22, 32'h0, SW, LHU, sc, m);
        checks++; if (rdata_M !== 32'h00008001) begin errors++; $display("FAIL lhu_zext got=%h exp=%h", rdata_M, 32'h00008001); end
        access(1'b0, 1'b1, 32'h20, 32'h0, SW, LW, sc, m);
        checks++; if (rdata_M !== 32'h80010000) begin errors++; $display("FAIL sh_lane got=%h exp=%h", rdata_M, 32'h80010000); end
    endtask

    task automatic test_misalign();
        int sc; logic m;
        access(1'b0, 1'b1, 32'h11, 32'h0, SW, LW, sc, m);
        checks++; if (m !== 1'b1) begin errors++; $display("FAIL lw_mis_flag got=%b exp=1", m); end
        checks++; if (sc !== 0) begin errors++; $display("FAIL lw_mis_stall got=%0d exp=0", sc); end
        checks++; if (rdata_M !== 32'h80010000) begin errors++; $display("FAIL lw_mis_rdata got=%h exp=%h", rdata_M, 32'h80010000); end
        access(1'b1, 1'b0, 32'h21, 32'h0000FFFF, SH, LW, sc, m);
        checks++; if (m !== 1'b1) begin errors++; $display("FAIL sh_mis_flag got=%b exp=1", m); end
        access(1'b0, 1'b1, 32'h20, 32'h0, SW, LW, sc, m);
        checks++; if (rdata_M !== 32'h80010000) begin errors++; $display("FAIL sh_mis_mem got=%h exp=%h", rdata_M, 32'h80010000); end
        access(1'b0, 1'b1, 32'h22, 32'h0, SW, LHU, sc, m);
        checks++; if (m !== 1'b0) begin errors++; $display("FAIL lhu_aligned_flag got=%b exp=0", m); end
    endtask

    task automatic test_reset_mid();
        int sc; logic m;
        access(1'b1, 1'b0, 32'h30, 32'h11112222, SW, LW, sc, m);
        @(posedge clk); #1;
        write_enable_dmem_M = 1'b1;
        alu_rsl_M           = 32'h30;
        wd_M                = 32'h12345678;
        store_sel_M         = SW;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        idle_inputs();
        @(posedge clk); #1;
        rst_n = 1'b1;
        checks++; if (stall_M !== 1'b0) begin errors++; $display("FAIL rstmid_stall got=%b exp=0", stall_M); end
        checks++; if (rdata_M !== 32'h0) begin errors++; $display("FAIL rstmid_rdata got=%h exp=%h", rdata_M, 32'h0); end
        access(1'b0, 1'b1, 32'h30, 32'h0, SW, LW, sc, m);
        checks++; if (sc !== 3) begin errors++; $display("FAIL rstmid_idle got=%0d exp=3", sc); end
        checks++; if (rdata_M !== 32'h11112222) begin errors++; $display("FAIL rstmid_discard got=%h exp=%h", rdata_M, 32'h11112222); end
    endtask

    task automatic test_wrap();
        int sc; logic m;
        access(1'b1, 1'b0, 32'h1000, 32'hA5A5A5A5, SW, LW, sc, m);
        access(1'b0, 1'b1, 32'h0, 32'h0, SW, LW, sc, m);
        checks++; if (rdata_M !== 32'hA5A5A5A5) begin errors++; $display("FAIL wrap got=%h exp=%h", rdata_M, 32'hA5A5A5A5); end
    endtask

    task automatic test_simultaneous();
        int sc; logic m;
        access(1'b0, 1'b1, 32'h10, 32'h0, SW, LW, sc, m);
        access(1'b1, 1'b1, 32'h40, 32'h01020304, SW, LW, sc, m);
        checks++; if (sc !== 3) begin errors++; $display("FAIL both_stall got=%0d exp=3", sc); end
        checks++; if (rdata_M !== 32'h80000000) begin errors++; $display("FAIL both_rdata got=%h exp=%h", rdata_M, 32'h80000000); end
        access(1'b0, 1'b1, 32'h40, 32'h0, SW, LW, sc, m);
        checks++; if (rdata_M !== 32'h01020304) begin errors++; $display("FAIL both_store got=%h exp=%h", rdata_M, 32'h01020304); end
    endtask

    task automatic test_back_to_back();
        int sc; logic m;
        access(1'b0, 1'b1, 32'h12, 32'h0, SW, LH, sc, m);
        checks++; if (rdata_M !== 32'hFFFF8000) begin errors++; $display("FAIL b2b_first got=%h exp=%h", rdata_M, 32'hFFFF8000); end
        access(1'b0, 1'b1, 32'h41, 32'h0, SW, LB, sc, m);
        checks++; if (sc !== 3) begin errors++; $display("FAIL b2b_stall got=%0d exp=3", sc); end
        checks++; if (rdata_M !== 32'h00000003) begin errors++; $display("FAIL b2b_second got=%h exp=%h", rdata_M, 32'h3); end
    endtask

    initial begin
        idle_inputs();
        rst_n = 1'b0;
        test_reset();
        test_word();
        test_byte();
        test_half();
        test_misalign();
        test_reset_mid();
        test_wrap();
        test_simultaneous();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
